pipearch_dma_read_reorder: RTL and testbench
============================================

Name: pipearch_dma_read_reorder

Overview:
- Reorder buffer between the GLM read requester and the CCI-P read DMA channel.
- Accepts in-order line read requests, tags each with a free slot index and issues it downstream.
- Stores out-of-order 512-bit responses by tag and returns them to the consumer in request order.
- Also bounds outstanding reads so that responses never overflow local storage.

Parameters:
- DEPTH, 64, number of reorder slots and maximum outstanding reads; power of two, 4..512.
- ADDR_W, 42, cache-line address width.
- DATA_W, 512, line width in bits.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  consumer read request valid.
- req_addr  in  ADDR_W  line address.
- req_ready  out  1  request accepted when req_valid && req_ready.
- issue_valid  out  1  request to DMA read channel.
- issue_addr  out  ADDR_W  forwarded address.
- issue_tag  out  log2(DEPTH)  slot index; returned with the response.
- issue_almfull  in  1  DMA channel almost full; blocks issue.
- rsp_valid  in  1  response beat valid; no backpressure.
- rsp_tag  in  log2(DEPTH)  slot of the response.
- rsp_data  in  DATA_W  response line.
- out_valid  out  1  in-order data valid.
- out_data  out  DATA_W  in-order data.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- outstanding  out  log2(DEPTH)+1  slots allocated and not yet retired.
- tag_error  out  1  sticky flag: response arrived for a slot not awaiting data.

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - alloc_ptr, retire_ptr, outstanding and the slot valid/pending bits;
  - issue_valid, out_valid and tag_error.
  - out_data, issue_addr and issue_tag are don't-care.
- Reset mid-operation drops all in-flight state. Late responses arriving after reset deassertion set tag_error; this is required behaviour, not a bug.
- req_ready = !issue_almfull && (outstanding < DEPTH), combinational.
- Issue is a pass-through register: on accept, the next cycle drives issue_valid=1 with issue_addr=req_addr and issue_tag=alloc_ptr. issue_valid otherwise 0; fixed latency of 1 cycle.
- On accept: pending[alloc_ptr]<=1; alloc_ptr increments modulo DEPTH with natural wrap.
- Response handling:
  - If pending[rsp_tag] && !valid[rsp_tag]: write rsp_data to slot RAM, set valid[rsp_tag].
  - Else drop the beat and set tag_error, which stays set until reset.
- Output pipeline has two stages:
  - RD: if valid[retire_ptr] and the output register is free or being drained this cycle, issue a RAM read. Then clear pending/valid at retire_ptr and increment retire_ptr.
  - OUT: next cycle, RAM data lands in the output register and out_valid=1.
  - Holds out_data stable while out_valid && !out_ready.
- Minimum latency from rsp_valid to out_valid: 2 cycles (write edge, read edge).
- Sustained throughput is 1 beat/cycle when out_ready=1.
- outstanding rules:
  - Increments on accept, decrements on RD retire; both in one cycle leaves it unchanged.
  - Range 0..DEPTH; full at DEPTH deasserts req_ready.
- A slot is reusable the cycle after its retire; a same-cycle accept of a just-retired slot is not allowed (full check uses the registered count).
- A response to the slot currently being read cannot occur (valid already set); the bench asserts this.
- issue_almfull rising blocks new accepts the same cycle; an already-registered issue still goes out.

Decomposition:
- Shared package pipearch_common carries:
  - the t_rob_tag width function (clog2(DEPTH));
  - DATA_W/ADDR_W defaults.
- One sub-module, pipearch_rob_ram: simple dual-port RAM, DEPTH x DATA_W, registered read, write-first not required.

Test Plan:
- In-order responses: DEPTH=8, 8 requests at addr 0x100..0x107, responses with tags 0..7 back-to-back -> out_data sequence matches; 2-cycle latency; outstanding returns to 0.
- Reverse order: 4 requests, responses with tags 3,2,1,0 -> no out_valid until tag 0 arrives, then 4 beats on consecutive cycles in order 0,1,2,3.
- Full: DEPTH=8, 8 requests without responses -> req_ready=0 with outstanding=8. One response with tag 0 retired -> req_ready=1 the next cycle; the new request gets issue_tag=0 (wrap).
- Backpressure: out_ready=0 for 10 cycles with 3 responses buffered -> out_data held stable; release gives 3 consecutive beats with no loss or duplication.
- Spurious and duplicate: a response with tag 5 when nothing is outstanding -> tag_error=1 and no out_valid. A duplicate response for tag 0 -> tag_error=1 and only one beat output.
- Almfull and reset: issue_almfull=1 -> req_ready=0 and no issue. Reset asserted with 3 outstanding -> all outputs 0 immediately; after release, outstanding=0 and the first new issue_tag=0.

Source files
------------

// File: rtl/pipearch_common.sv
// Shared definitions for the pipearch DMA blocks: default line/address widths
// and the reorder-tag width helper.
package pipearch_common;

  localparam int ADDR_W_DEF = 42;
  localparam int DATA_W_DEF = 512;

  function automatic int rob_tag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipearch_rob_ram.sv
// Slot storage for the reorder buffer: simple dual-port RAM with a registered read.
// The read register doubles as the consumer-facing output register.
module pipearch_rob_ram
  import pipearch_common::*;
#(
  parameter  int DEPTH  = 64,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int TAG_W  = rob_tag_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [TAG_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Read data only changes when a new slot is retired, so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pipearch_dma_read_reorder.sv
// Reorder buffer between the GLM read requester and the CCI-P read channel:
// tags requests with slot indices and returns out-of-order responses in request order.
module pipearch_dma_read_reorder
  import pipearch_common::*;
#(
  parameter  int DEPTH  = 64,
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int TAG_W  = rob_tag_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              issue_valid,
  output logic [ADDR_W-1:0] issue_addr,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              issue_almfull,
  input  logic              rsp_valid,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [TAG_W:0]    outstanding,
  output logic              tag_error
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  alloc_q, alloc_d, retire_q, retire_d;
  logic [TAG_W:0]    outstanding_q, outstanding_d;
  logic [DEPTH-1:0]  pending_q, pending_d, valid_q, valid_d;
  logic              issue_valid_q, issue_valid_d;
  logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
  logic [TAG_W-1:0]  issue_tag_q, issue_tag_d;
  logic              out_valid_q, out_valid_d;
  logic              tag_error_q, tag_error_d;
  logic              accept, rsp_ok, rd_fire;

  // Full check uses the registered count, so a slot retired this cycle is not reused until the next.
  assign req_ready = !issue_almfull && (outstanding_q < DEPTH_CNT);

  always_comb begin
    accept  = req_valid && req_ready;
    rsp_ok  = rsp_valid && pending_q[rsp_tag] && !valid_q[rsp_tag];
    rd_fire = valid_q[retire_q] && (!out_valid_q || out_ready);

    alloc_d       = alloc_q;
    retire_d      = retire_q;
    outstanding_d = outstanding_q;
    pending_d     = pending_q;
    valid_d       = valid_q;
    issue_valid_d = accept;
    issue_addr_d  = accept ? req_addr : issue_addr_q;
    issue_tag_d   = accept ? alloc_q : issue_tag_q;
    out_valid_d   = out_valid_q;
    tag_error_d   = tag_error_q;

    if (rsp_ok) begin
      valid_d[rsp_tag] = 1'b1;
    end else if (rsp_valid) begin
      tag_error_d = 1'b1;
    end

    if (rd_fire) begin
      pending_d[retire_q] = 1'b0;
      valid_d[retire_q]   = 1'b0;
      retire_d            = retire_q + TAG_W'(1);
    end

    if (accept) begin
      pending_d[alloc_q] = 1'b1;
      alloc_d            = alloc_q + TAG_W'(1);
    end

    if (accept && !rd_fire) begin
      outstanding_d = outstanding_q + (TAG_W+1)'(1);
    end else if (!accept && rd_fire) begin
      outstanding_d = outstanding_q - (TAG_W+1)'(1);
    end

    if (rd_fire) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_q       <= '0;
      retire_q      <= '0;
      outstanding_q <= '0;
      pending_q     <= '0;
      valid_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_addr_q  <= '0;
      issue_tag_q   <= '0;
      out_valid_q   <= 1'b0;
      tag_error_q   <= 1'b0;
    end else begin
      alloc_q       <= alloc_d;
      retire_q      <= retire_d;
      outstanding_q <= outstanding_d;
      pending_q     <= pending_d;
      valid_q       <= valid_d;
      issue_valid_q <= issue_valid_d;
      issue_addr_q  <= issue_addr_d;
      issue_tag_q   <= issue_tag_d;
      out_valid_q   <= out_valid_d;
      tag_error_q   <= tag_error_d;
    end
  end

  pipearch_rob_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (rsp_ok),
    .wr_addr (rsp_tag),
    .wr_data (rsp_data),
    .rd_en   (rd_fire),
    .rd_addr (retire_q),
    .rd_data (out_data)
  );

  assign issue_valid = issue_valid_q;
  assign issue_addr  = issue_addr_q;
  assign issue_tag   = issue_tag_q;
  assign out_valid   = out_valid_q;
  assign outstanding = outstanding_q;
  assign tag_error   = tag_error_q;

endmodule

// File: tb/tb_pipearch_dma_read_reorder.sv
// Scenario bench for the read reorder buffer; expected beats are queued at request
// time and popped by a monitor whenever the consumer handshake completes.
module tb_pipearch_dma_read_reorder;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 42;
  localparam int DATA_W = 512;
  localparam int TAG_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [TAG_W-1:0]  issue_tag;
  logic              issue_almfull;
  logic              rsp_valid;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [TAG_W:0]    outstanding;
  logic              tag_error;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int beat_cnt  = 0;
  int tag_cnt   = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] tag_addr [DEPTH];

  pipearch_dma_read_reorder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .issue_tag     (issue_tag),
    .issue_almfull (issue_almfull),
    .rsp_valid     (rsp_valid),
    .rsp_tag       (rsp_tag),
    .rsp_data      (rsp_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .outstanding   (outstanding),
    .tag_error     (tag_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DATA_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {8{a[31:0], ~a[31:0]}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard consumer: every completed output handshake must match the oldest queued line.
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    if (reset && out_valid && out_ready) begin
      beat_cnt++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL out_beat: got beat %h, required no beat", out_data[63:0]);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) $display("[TB] FAIL out_beat: got %h, required %h", out_data[63:0], e[63:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic send_req(input logic [ADDR_W-1:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    sample();
    total_cnt++;
    if (req_ready !== 1'b1) $display("[TB] FAIL req_ready: got %b, required 1", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 1'b0;
    total_cnt++;
    if (issue_valid !== 1'b1 || issue_addr !== a || issue_tag !== TAG_W'(tag_cnt))
      $display("[TB] FAIL issue: got v=%b a=%h t=%0d, required v=1 a=%h t=%0d",
               issue_valid, issue_addr, issue_tag, a, tag_cnt);
    else pass_cnt++;
    tag_addr[tag_cnt] = a;
    exp_q.push_back(line_of(a));
    tag_cnt = (tag_cnt + 1) % DEPTH;
  endtask

  task automatic send_rsp(input int t);
    rsp_valid = 1'b1;
    rsp_tag   = TAG_W'(t);
    rsp_data  = line_of(tag_addr[t]);
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    exp_q.delete();
    tag_cnt = 0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; issue_almfull = 1'b0;
    rsp_valid = 1'b0; rsp_tag = '0; rsp_data = '0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tag_addr[i] = '0;
    tick();
    sample();
    total_cnt++;
    if (issue_valid !== 1'b0 || out_valid !== 1'b0) $display("[TB] FAIL reset_valids: got issue=%b out=%b, required 0 0", issue_valid, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (outstanding !== '0 || tag_error !== 1'b0) $display("[TB] FAIL reset_state: got outstanding=%0d tag_error=%b, required 0 0", outstanding, tag_error);
    else pass_cnt++;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 8; i++) send_req(ADDR_W'(32'h100 + i));
    for (int i = 0; i < 8; i++) begin
      rsp_valid = 1'b1;
      rsp_tag   = TAG_W'(i);
      rsp_data  = line_of(tag_addr[i]);
      sample();
      if (i < 3) begin
        total_cnt++;
        if (out_valid !== (i == 2)) $display("[TB] FAIL inorder_latency: cycle %0d got out_valid=%b, required %b", i, out_valid, i == 2);
        else pass_cnt++;
      end
      tick();
    end
    rsp_valid = 1'b0;
    repeat (6) tick();
    total_cnt++;
    if (outstanding !== '0 || exp_q.size() != 0) $display("[TB] FAIL inorder_drain: got outstanding=%0d left=%0d, required 0 0", outstanding, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) send_req(ADDR_W'(32'h200 + i));
    sample();
    total_cnt++;
    if (outstanding !== 4'd8 || req_ready !== 1'b0) $display("[TB] FAIL full: got outstanding=%0d ready=%b, required 8 0", outstanding, req_ready);
    else pass_cnt++;
    tick();
    send_rsp(0);
    sample();
    total_cnt++;
    if (req_ready !== 1'b0) $display("[TB] FAIL full_hold: got ready=%b, required 0", req_ready);
    else pass_cnt++;
    tick();
    sample();
    total_cnt++;
    if (req_ready !== 1'b1 || outstanding !== 4'd7) $display("[TB] FAIL full_release: got ready=%b outstanding=%0d, required 1 7", req_ready, outstanding);
    else pass_cnt++;
    tick();
    send_req(ADDR_W'(32'h300));
    for (int t = 1; t < 8; t++) send_rsp(t);
    send_rsp(0);
    repeat (6) tick();
    total_cnt++;
    if (outstanding !== '0 || exp_q.size() != 0) $display("[TB] FAIL full_drain: got outstanding=%0d left=%0d, required 0 0", outstanding, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reverse();
    int t0;
    bit found;
    t0 = tag_cnt;
    for (int i = 0; i < 4; i++) send_req(ADDR_W'(32'h400 + i));
    for (int k = 3; k >= 1; k--) begin
      send_rsp((t0 + k) % DEPTH);
      sample();
      total_cnt++;
      if (out_valid !== 1'b0) $display("[TB] FAIL reverse_wait: got out_valid=%b after tag %0d, required 0", out_valid, (t0 + k) % DEPTH);
      else pass_cnt++;
      tick();
    end
    send_rsp(t0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      sample();
      found = out_valid;
    end
    total_cnt++;
    if (!found) $display("[TB] FAIL reverse_timeout: got no out_valid, required a beat");
    else pass_cnt++;
    for (int k = 1; k < 4; k++) begin
      sample();
      total_cnt++;
      if (out_valid !== 1'b1) $display("[TB] FAIL reverse_burst: beat %0d got out_valid=%b, required 1", k, out_valid);
      else pass_cnt++;
    end
    sample();
    total_cnt++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) $display("[TB] FAIL reverse_end: got out_valid=%b left=%0d, required 0 0", out_valid, exp_q.size());
    else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    int t0;
    bit found;
    t0 = tag_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_req(ADDR_W'(32'h500 + i));
    for (int i = 0; i < 3; i++) send_rsp((t0 + i) % DEPTH);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      sample();
      found = out_valid;
    end
    total_cnt++;
    if (!found) $display("[TB] FAIL bp_timeout: got no out_valid, required a beat");
    else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      sample();
      total_cnt++;
      if (out_valid !== 1'b1 || exp_q.size() == 0 || out_data !== exp_q[0])
        $display("[TB] FAIL bp_hold: cycle %0d got v=%b d=%h, required held head beat", k, out_valid, out_data[63:0]);
      else pass_cnt++;
    end
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      total_cnt++;
      if (out_valid !== 1'b1) $display("[TB] FAIL bp_release: beat %0d got out_valid=%b, required 1", k, out_valid);
      else pass_cnt++;
    end
    sample();
    total_cnt++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) $display("[TB] FAIL bp_end: got out_valid=%b left=%0d, required 0 0", out_valid, exp_q.size());
    else pass_cnt++;
    tick();
  endtask

  task automatic test_spurious();
    int beats;
    sample();
    total_cnt++;
    if (tag_error !== 1'b0) $display("[TB] FAIL spurious_pre: got tag_error=%b, required 0", tag_error);
    else pass_cnt++;
    tick();
    send_rsp(5);
    beats = 0;
    for (int k = 0; k < 4; k++) begin
      sample();
      if (out_valid) beats++;
    end
    total_cnt++;
    if (tag_error !== 1'b1 || beats != 0) $display("[TB] FAIL spurious: got tag_error=%b beats=%0d, required 1 0", tag_error, beats);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_duplicate();
    int beats;
    send_req(ADDR_W'(32'h600));
    send_rsp(0);
    send_rsp(0);
    beats = 0;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (out_valid) beats++;
    end
    total_cnt++;
    if (tag_error !== 1'b1 || beats != 1 || exp_q.size() != 0)
      $display("[TB] FAIL duplicate: got tag_error=%b beats=%0d left=%0d, required 1 1 0", tag_error, beats, exp_q.size());
    else pass_cnt++;
    tick();
  endtask

  task automatic test_almfull_reset();
    issue_almfull = 1'b1;
    req_valid = 1'b1;
    req_addr  = ADDR_W'(32'h700);
    sample();
    total_cnt++;
    if (req_ready !== 1'b0) $display("[TB] FAIL almfull_ready: got %b, required 0", req_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (issue_valid !== 1'b0 || outstanding !== '0) $display("[TB] FAIL almfull_issue: got issue=%b outstanding=%0d, required 0 0", issue_valid, outstanding);
    else pass_cnt++;
    issue_almfull = 1'b0;
    req_addr = ADDR_W'(32'h701);
    tick();
    issue_almfull = 1'b1;
    req_valid = 1'b0;
    tag_addr[0] = ADDR_W'(32'h701);
    exp_q.push_back(line_of(ADDR_W'(32'h701)));
    tag_cnt = 1;
    sample();
    total_cnt++;
    if (issue_valid !== 1'b1 || issue_tag !== 3'd0 || issue_addr !== ADDR_W'(32'h701))
      $display("[TB] FAIL almfull_inflight: got v=%b t=%0d a=%h, required 1 0 701", issue_valid, issue_tag, issue_addr);
    else pass_cnt++;
    tick();
    issue_almfull = 1'b0;
    send_req(ADDR_W'(32'h702));
    send_req(ADDR_W'(32'h703));
    total_cnt++;
    if (outstanding !== 4'd3) $display("[TB] FAIL pre_reset_outstanding: got %0d, required 3", outstanding);
    else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (issue_valid !== 1'b0 || out_valid !== 1'b0 || outstanding !== '0 || tag_error !== 1'b0)
      $display("[TB] FAIL async_reset: got issue=%b out=%b outstanding=%0d err=%b, required all 0", issue_valid, out_valid, outstanding, tag_error);
    else pass_cnt++;
    tick();
    exp_q.delete();
    tag_cnt = 0;
    reset = 1'b1;
    tick();
    send_req(ADDR_W'(32'h800));
    send_rsp(1);
    sample();
    total_cnt++;
    if (tag_error !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL late_rsp: got tag_error=%b out_valid=%b, required 1 0", tag_error, out_valid);
    else pass_cnt++;
    tick();
    send_rsp(0);
    repeat (5) tick();
    total_cnt++;
    if (exp_q.size() != 0 || outstanding !== '0) $display("[TB] FAIL post_reset_drain: got left=%0d outstanding=%0d, required 0 0", exp_q.size(), outstanding);
    else pass_cnt++;
  endtask

  initial begin
    $display("[TB] starting read reorder scenarios");
    test_reset();
    test_in_order();
    test_full();
    test_reverse();
    test_backpressure();
    test_spurious();
    apply_reset();
    test_duplicate();
    apply_reset();
    test_almfull_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
